// File: rtl/enc_pkg.sv
// Shared defaults, state encoding and accumulator sizing for the batched encoder layer.
// Build option: define ENC_RELU_EN to clamp negative outputs to zero.
package enc_pkg;

   localparam int BITSIZE_DEF  = 16;
   localparam int FRAC_DEF     = 11;
   localparam int IN_SIZE_DEF  = 10;
   localparam int OUT_SIZE_DEF = 92;
   localparam int BATCH_DEF    = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_BIAS,
      ST_DONE
   } state_e;

   // Full signed product width plus headroom for IN_SIZE additions and one guard bit.
   function automatic int acc_width(input int bitsize, input int in_size);
      return 2 * bitsize + $clog2(in_size) + 1;
   endfunction

endpackage

// File: rtl/enc_mac_lane.sv
// One shared MAC lane: accumulates x*w, then shifts by FRAC, adds bias and saturates.
// Build option: ENC_RELU_EN clamps negative saturated results to zero.
module enc_mac_lane
   import enc_pkg::*;
#(
   parameter int BITSIZE = BITSIZE_DEF,
   parameter int FRAC    = FRAC_DEF,
   parameter int IN_SIZE = IN_SIZE_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clr_i,
   input  logic                      mac_en_i,
   input  logic signed [BITSIZE-1:0] x_i,
   input  logic signed [BITSIZE-1:0] w_i,
   input  logic signed [BITSIZE-1:0] b_i,
   output logic signed [BITSIZE-1:0] res_o
);

   localparam int AW = acc_width(BITSIZE, IN_SIZE);
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

   logic signed [AW-1:0]        acc_q;
   logic signed [AW-1:0]        acc_d;
   logic signed [2*BITSIZE-1:0] prod;
   logic signed [AW-1:0]        biased;

   always_comb begin
      prod  = (2*BITSIZE)'(x_i) * (2*BITSIZE)'(w_i);
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (mac_en_i) begin
         acc_d = acc_q + AW'(prod);
      end
   end

   // Arithmetic shift floors toward minus infinity, matching Qx.FRAC truncation.
   always_comb begin
      biased = (acc_q >>> FRAC) + AW'(b_i);
      if (biased > SAT_MAX) begin
         res_o = SAT_MAX[BITSIZE-1:0];
      end else if (biased < SAT_MIN) begin
         res_o = SAT_MIN[BITSIZE-1:0];
      end else begin
         res_o = biased[BITSIZE-1:0];
      end
`ifdef ENC_RELU_EN
      if (res_o[BITSIZE-1]) begin
         res_o = '0;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/enc_batch_sched.sv
// Dense layer y = sat((W*x >> FRAC) + b) computed tile by tile on BATCH shared MAC lanes.
// Build option: ENC_RELU_EN enables ReLU on the written outputs.
module enc_batch_sched
   import enc_pkg::*;
#(
   parameter int BITSIZE  = BITSIZE_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int IN_SIZE  = IN_SIZE_DEF,
   parameter int OUT_SIZE = OUT_SIZE_DEF,
   parameter int BATCH    = BATCH_DEF
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [BITSIZE*IN_SIZE-1:0]          x,
   input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
   input  logic [BITSIZE*OUT_SIZE-1:0]         b,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [BITSIZE*OUT_SIZE-1:0]         y,
   output logic                                busy
);

   localparam int NT = (OUT_SIZE + BATCH - 1) / BATCH;
   localparam int TW = (NT > 1) ? $clog2(NT) : 1;
   localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(NT - 1);
   localparam logic [KW-1:0] K_LAST = KW'(IN_SIZE - 1);

   state_e                    state_q;
   logic [TW-1:0]             tile_q;
   logic [KW-1:0]             k_q;
   logic signed [BITSIZE-1:0] x_q [IN_SIZE];
   logic signed [BITSIZE-1:0] y_q [OUT_SIZE];
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic                      busy_q;

   logic                      acc_clr;
   logic                      acc_en;
   logic signed [BITSIZE-1:0] x_k;
   logic signed [BITSIZE-1:0] lane_res [BATCH];

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   always_comb begin
      acc_clr = ((state_q == ST_IDLE) && in_valid) || (state_q == ST_BIAS);
      acc_en  = (state_q == ST_MAC);
      x_k     = x_q[k_q];
   end

   for (genvar j = 0; j < BATCH; j++) begin : g_lane
      int                        o_idx;
      logic signed [BITSIZE-1:0] w_sel;
      logic signed [BITSIZE-1:0] b_sel;

      // Lanes past OUT_SIZE in the final partial tile see zero operands.
      always_comb begin
         o_idx = int'(tile_q) * BATCH + j;
         w_sel = '0;
         b_sel = '0;
         if (o_idx < OUT_SIZE) begin
            w_sel = w[(o_idx * IN_SIZE + int'(k_q)) * BITSIZE +: BITSIZE];
            b_sel = b[o_idx * BITSIZE +: BITSIZE];
         end
      end

      enc_mac_lane #(
         .BITSIZE (BITSIZE),
         .FRAC    (FRAC),
         .IN_SIZE (IN_SIZE)
      ) u_lane (
         .clk_i    (clk),
         .rst_i    (reset),
         .clr_i    (acc_clr),
         .mac_en_i (acc_en),
         .x_i      (x_k),
         .w_i      (w_sel),
         .b_i      (b_sel),
         .res_o    (lane_res[j])
      );
   end

   for (genvar o = 0; o < OUT_SIZE; o++) begin : g_ypack
      assign y[o*BITSIZE +: BITSIZE] = y_q[o];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tile_q      <= '0;
         k_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int unsigned i = 0; i < IN_SIZE; i++) x_q[i] <= '0;
         for (int unsigned o = 0; o < OUT_SIZE; o++) y_q[o] <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  for (int unsigned i = 0; i < IN_SIZE; i++) begin
                     x_q[i] <= x[i*BITSIZE +: BITSIZE];
                  end
                  tile_q     <= '0;
                  k_q        <= '0;
                  state_q    <= ST_MAC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_MAC: begin
               if (k_q == K_LAST) begin
                  k_q     <= '0;
                  state_q <= ST_BIAS;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            ST_BIAS: begin
               for (int unsigned j = 0; j < BATCH; j++) begin
                  if (int'(tile_q) * BATCH + int'(j) < OUT_SIZE) begin
                     y_q[int'(tile_q) * BATCH + int'(j)] <= lane_res[j];
                  end
               end
               if (tile_q == T_LAST) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  tile_q  <= tile_q + 1'b1;
                  state_q <= ST_MAC;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
